// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle core: word RAM in the lower half of the
// address space, LED / cycle counter / compare timer / transmit-only UART above it.
module data_mem_mmio #(
  parameter int RAM_WORDS    = 128,
  parameter int CLKS_PER_BIT = 434,
  parameter int LED_WIDTH    = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [9:0]           DIR_DMEM,
  input  logic [31:0]          DATA_WRITE_DMEM,
  input  logic                 READ,
  input  logic                 WRITE,
  output logic [31:0]          DATA_READ_DMEM,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 UART_TX,
  output logic                 TIMER_IRQ
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] SEL_LED    = 3'd0;
  localparam logic [2:0] SEL_CYCLE  = 3'd1;
  localparam logic [2:0] SEL_CMP    = 3'd2;
  localparam logic [2:0] SEL_STATUS = 3'd3;
  localparam logic [2:0] SEL_UART   = 3'd4;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // Address decode
  logic          is_mmio;
  logic [2:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram;
  logic          wr_led;
  logic          wr_cycle;
  logic          wr_cmp;
  logic          wr_status;
  logic          wr_uart;
  logic          unused_addr_bits;

  assign is_mmio   = DIR_DMEM[9];
  assign reg_sel   = DIR_DMEM[4:2];
  assign ram_idx   = DIR_DMEM[2 +: AW];
  assign wr_ram    = WRITE && !is_mmio;
  assign wr_led    = WRITE && is_mmio && (reg_sel == SEL_LED);
  assign wr_cycle  = WRITE && is_mmio && (reg_sel == SEL_CYCLE);
  assign wr_cmp    = WRITE && is_mmio && (reg_sel == SEL_CMP);
  assign wr_status = WRITE && is_mmio && (reg_sel == SEL_STATUS);
  assign wr_uart   = WRITE && is_mmio && (reg_sel == SEL_UART);
  assign unused_addr_bits = ^{DIR_DMEM[1:0], DIR_DMEM[8:5]};

  // Data RAM: contents survive reset, write lands on the edge
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge CLK) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= DATA_WRITE_DMEM;
    end
  end

  // Peripheral registers
  logic [LED_WIDTH-1:0] led_q,   led_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [31:0]          cmp_q,   cmp_d;
  logic                 flag_q,  flag_d;
  logic                 cmp_hit;

  assign cmp_hit = (cycle_q == cmp_q) && (cmp_q != 32'd0);

  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    cmp_d   = cmp_q;
    flag_d  = flag_q;
    if (wr_led) begin
      led_d = DATA_WRITE_DMEM[LED_WIDTH-1:0];
    end
    if (wr_cycle) begin
      cycle_d = DATA_WRITE_DMEM;
    end
    if (wr_cmp) begin
      cmp_d = DATA_WRITE_DMEM;
    end
    if (wr_status && DATA_WRITE_DMEM[0]) begin
      flag_d = 1'b0;
    end
    // A compare hit in the same cycle as a software clear must not be lost
    if (cmp_hit) begin
      flag_d = 1'b1;
    end
  end

  // UART transmitter
  uart_state_e state_q, state_d;
  logic [DW-1:0] div_q,   div_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;
  logic          uart_busy;
  logic          div_done;

  assign uart_busy = (state_q != UART_IDLE);
  assign div_done  = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      UART_IDLE: begin
        if (wr_uart) begin
          state_d = UART_START;
          div_d   = '0;
          bit_d   = '0;
          shift_d = DATA_WRITE_DMEM[7:0];
        end
      end
      UART_START: begin
        if (div_done) begin
          state_d = UART_DATA;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (div_done) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (div_done) begin
          state_d = UART_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // Line level follows the state being entered so the output is a clean flop
    unique case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q   <= '0;
      cycle_q <= '0;
      cmp_q   <= '0;
      flag_q  <= 1'b0;
      state_q <= UART_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Zero-latency read path; the core consumes load data in the same cycle
  logic [31:0] mmio_rdata;
  logic [31:0] led_rdata;

  always_comb begin
    led_rdata = '0;
    led_rdata[LED_WIDTH-1:0] = led_q;
    mmio_rdata = '0;
    case (reg_sel)
      SEL_LED:    mmio_rdata = led_rdata;
      SEL_CYCLE:  mmio_rdata = cycle_q;
      SEL_CMP:    mmio_rdata = cmp_q;
      SEL_STATUS: mmio_rdata = {31'b0, flag_q};
      SEL_UART:   mmio_rdata = {31'b0, uart_busy};
      default:    mmio_rdata = '0;
    endcase
    DATA_READ_DMEM = '0;
    if (READ) begin
      DATA_READ_DMEM = is_mmio ? mmio_rdata : ram_q[ram_idx];
    end
  end

  assign LEDS      = led_q;
  assign UART_TX   = tx_q;
  assign TIMER_IRQ = flag_q;

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory subsystem directly downstream of the single-cycle core's data port. It consumes the core's data address, write data and READ/WRITE strobes, and returns read data in the same cycle. Lower half of the address space is a word RAM. Upper half holds memory-mapped peripherals: LED register, free-running cycle counter, compare timer with interrupt flag, and a transmit-only UART.

Parameters:
RAM_WORDS, 128, depth of data RAM in 32-bit words (power of two, max 128)
CLKS_PER_BIT, 434, UART bit period in CLK cycles (>=2)
LED_WIDTH, 8, width of LED output register (1..32)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
DIR_DMEM  input  10  byte address from core; bits [1:0] ignored (word access only)
DATA_WRITE_DMEM  input  32  store data from core
READ  input  1  load strobe
WRITE  input  1  store strobe
DATA_READ_DMEM  output  32  load data, combinational from DIR_DMEM/READ
LEDS  output  LED_WIDTH  LED register
UART_TX  output  1  serial line, idle high
TIMER_IRQ  output  1  timer compare flag

Behaviour:
- Clocking/reset: one clock CLK; RESET is synchronous, active-high. On reset: LEDS=0, CYCLE=0, TIMER_CMP=0, flag=0 (TIMER_IRQ=0), UART FSM=IDLE, UART_TX=1, busy=0, divider/bit counters=0. RAM contents not reset.
- Decode: DIR_DMEM[9]=0 -> RAM word index DIR_DMEM[8:2] mod RAM_WORDS. DIR_DMEM[9]=1 -> MMIO, register select DIR_DMEM[4:2]:
  0 LED (R/W, low LED_WIDTH bits, upper read bits 0)
  1 CYCLE (R/W, write loads value)
  2 TIMER_CMP (R/W)
  3 STATUS: read {31'b0,flag}; write with bit0=1 clears flag
  4 UART: write loads byte [7:0] and starts frame if not busy, ignored if busy; read {31'b0,busy}
  5-7 unmapped: reads 0, writes ignored; DIR_DMEM[8:5] ignored in MMIO
- Read path: DATA_READ_DMEM = selected value when READ=1, else 32'h0. Zero-latency (combinational), required by the single-cycle core.
- Write path: when WRITE=1, target updated at next rising edge. READ and WRITE together: write performed, read returns pre-edge value.
- CYCLE: increments every cycle, wraps 32'hFFFFFFFF->0. CPU write in same cycle overrides increment.
- Timer: at a rising edge where CYCLE==TIMER_CMP and TIMER_CMP!=0, flag<=1. TIMER_IRQ=flag. A set condition in the same cycle as a STATUS clear leaves flag=1 (set wins).
- UART FSM: IDLE -> START (1 bit, TX=0) -> DATA (8 bits, LSB first) -> STOP (1 bit, TX=1) -> IDLE.
  - Each state lasts CLKS_PER_BIT cycles, counted by a divider.
  - busy=1 from the edge that accepts the write until STOP completes; a frame is exactly 10*CLKS_PER_BIT cycles.
  - A new write in the cycle busy returns to 0 is accepted.
  - RESET mid-frame aborts: TX=1 immediately after the edge, byte lost.

Test Plan:
- Reset then READ=1 at 0x200, 0x20C, 0x210 -> all return 0; UART_TX=1, LEDS=0, TIMER_IRQ=0.
- Write 0xDEADBEEF to 0x004, 0x12345678 to 0x1FC; read both back -> same values. Read 0x004 with READ=0 -> 0. Write+read 0x004 same cycle -> old value, new value next cycle.
- Write 0x1A5 to 0x200 -> LEDS=8'hA5, read 0x200 -> 0x000000A5. Read 0x214 -> 0.
- Write CYCLE=0, TIMER_CMP=10 -> TIMER_IRQ rises after the 11th edge. Write 1 to 0x20C -> IRQ clears. Write CYCLE=0xFFFFFFFF -> reads 0 two cycles later.
- CLKS_PER_BIT=4, write 0x55 to 0x210 -> TX sequence 0,1,0,1,0,1,0,1,0,1 (4 cycles each), busy=1 for 40 cycles. Second write while busy is ignored.
- Start a frame, assert RESET at bit 3 -> TX=1, busy=0 next cycle. A new write 0xFF then sends a full clean frame.
